// File: rtl/mig_app_responder_if.sv
// DDR3 UI application-port bundle between the FIFO command generator (master) and the memory responder (slave).
interface mig_app_responder_if;
    logic         init_calib_complete;
    logic [27:0]  app_addr;
    logic [2:0]   app_cmd;
    logic         app_en;
    logic         app_rdy;
    logic [127:0] app_wdf_data;
    logic [15:0]  app_wdf_mask;
    logic         app_wdf_wren;
    logic         app_wdf_end;
    logic         app_wdf_rdy;
    logic [127:0] app_rd_data;
    logic         app_rd_data_valid;
    logic         app_rd_data_end;
    logic         err;

    modport master (
        output app_addr, app_cmd, app_en, app_wdf_data, app_wdf_mask, app_wdf_wren, app_wdf_end,
        input  init_calib_complete, app_rdy, app_wdf_rdy, app_rd_data, app_rd_data_valid,
               app_rd_data_end, err
    );

    modport slave (
        input  app_addr, app_cmd, app_en, app_wdf_data, app_wdf_mask, app_wdf_wren, app_wdf_end,
        output init_calib_complete, app_rdy, app_wdf_rdy, app_rd_data, app_rd_data_valid,
               app_rd_data_end, err
    );
endinterface

// File: rtl/mig_app_responder.sv
// BRAM-backed DDR3 UI-port stand-in: in-order command/write-data queues, reads valid READ_LATENCY cycles after retire.
// Registered app_rdy/app_wdf_rdy gate on calibration, queue fullness and refresh; MIG_RESP_STALL_INJECT_EN adds LFSR stalls.
module mig_app_responder #(
    parameter int MEM_ADDR_WIDTH   = 10,
    parameter int CMDQ_DEPTH_LOG2  = 2,
    parameter int READ_LATENCY     = 8,
    parameter int CALIB_CYCLES     = 64,
    parameter int REFRESH_INTERVAL = 1024,
    parameter int REFRESH_CYCLES   = 16
) (
    input  logic uiclk,
    input  logic reset,
    mig_app_responder_if.slave app
);

    localparam int DEPTH = 1 << CMDQ_DEPTH_LOG2;
    localparam int QW    = CMDQ_DEPTH_LOG2;
    localparam int QCW   = CMDQ_DEPTH_LOG2 + 1;
    localparam int CW    = $clog2(CALIB_CYCLES + 1);
    localparam logic [QCW-1:0] Q_FULL   = QCW'(DEPTH);
    localparam logic [CW-1:0]  CAL_LAST = CW'(CALIB_CYCLES - 1);

    typedef struct packed {
        logic                      rd;
        logic [MEM_ADDR_WIDTH-1:0] addr;
    } cmd_t;

    typedef struct packed {
        logic [127:0] data;
        logic [15:0]  mask;
    } wdf_t;

    logic          calib;
    logic [CW-1:0] calib_cnt;
    logic          calib_n;

    cmd_t           cmdq [DEPTH];
    logic [QW-1:0]  cmd_wp, cmd_rp;
    logic [QCW-1:0] cmd_cnt, cmd_cnt_n;
    wdf_t           wdfq [DEPTH];
    logic [QW-1:0]  wdf_wp, wdf_rp;
    logic [QCW-1:0] wdf_cnt, wdf_cnt_n;

    logic         rdy_q, wdf_rdy_q, err_q, rd_vld_q;
    logic [127:0] rd_data_q;
    logic [127:0] mem [2**MEM_ADDR_WIDTH];

    logic cmd_legal, cmd_push, wdf_push, retire, rd_retire, wr_retire, err_set;
    logic refresh_stall, refresh_stall_n, inj_cmd, inj_wdf;
    logic last_vld;
    logic [MEM_ADDR_WIDTH-1:0] last_addr;
    cmd_t head;
    wdf_t wdf_head;
    logic unused_addr_bits;

    assign unused_addr_bits = ^{app.app_addr[27:MEM_ADDR_WIDTH+3], app.app_addr[2:0]};

    assign head      = cmdq[cmd_rp];
    assign wdf_head  = wdfq[wdf_rp];
    assign cmd_legal = (app.app_cmd == 3'b000) || (app.app_cmd == 3'b001);
    assign cmd_push  = app.app_en && rdy_q && cmd_legal;
    assign wdf_push  = app.app_wdf_wren && wdf_rdy_q;
    // A write waits at the head until its data beat exists; reads never wait.
    assign retire    = (cmd_cnt != '0) && !refresh_stall && (head.rd || (wdf_cnt != '0));
    assign rd_retire = retire && head.rd;
    assign wr_retire = retire && !head.rd;
    assign calib_n   = calib || (calib_cnt == CAL_LAST);

    assign err_set = (app.app_en && rdy_q && !cmd_legal)
                   || (app.app_wdf_wren && !app.app_wdf_end)
                   || (app.app_en && !rdy_q)
                   || (app.app_wdf_wren && !wdf_rdy_q);

    always_comb begin
        cmd_cnt_n = cmd_cnt;
        if (cmd_push && !retire)
            cmd_cnt_n = cmd_cnt + QCW'(1);
        else if (!cmd_push && retire)
            cmd_cnt_n = cmd_cnt - QCW'(1);
        wdf_cnt_n = wdf_cnt;
        if (wdf_push && !wr_retire)
            wdf_cnt_n = wdf_cnt + QCW'(1);
        else if (!wdf_push && wr_retire)
            wdf_cnt_n = wdf_cnt - QCW'(1);
    end

    generate
        if (REFRESH_INTERVAL > 0 && REFRESH_CYCLES > 0) begin : g_refresh
            localparam int RW = (REFRESH_INTERVAL > 1) ? $clog2(REFRESH_INTERVAL) : 1;
            localparam logic [RW-1:0] REF_LAST  = RW'(REFRESH_INTERVAL - 1);
            localparam logic [RW-1:0] REF_START = RW'(REFRESH_INTERVAL - REFRESH_CYCLES);
            logic [RW-1:0] ref_cnt, ref_cnt_n;

            // Stall occupies the last REFRESH_CYCLES slots of every interval.
            assign ref_cnt_n       = (ref_cnt == REF_LAST) ? '0 : ref_cnt + RW'(1);
            assign refresh_stall   = (ref_cnt >= REF_START);
            assign refresh_stall_n = (ref_cnt_n >= REF_START);

            always_ff @(posedge uiclk or posedge reset) begin
                if (reset)
                    ref_cnt <= '0;
                else
                    ref_cnt <= ref_cnt_n;
            end
        end else begin : g_no_refresh
            assign refresh_stall   = 1'b0;
            assign refresh_stall_n = 1'b0;
        end
    endgenerate

`ifdef MIG_RESP_STALL_INJECT_EN
    logic [15:0] lfsr, lfsr_n;

    assign lfsr_n  = {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
    assign inj_cmd = (lfsr_n[2:0] == 3'b000);
    assign inj_wdf = (lfsr_n[10:8] == 3'b000);

    always_ff @(posedge uiclk or posedge reset) begin
        if (reset)
            lfsr <= 16'hACE1;
        else
            lfsr <= lfsr_n;
    end
`else
    assign inj_cmd = 1'b0;
    assign inj_wdf = 1'b0;
`endif

    always_ff @(posedge uiclk or posedge reset) begin
        if (reset) begin
            calib     <= 1'b0;
            calib_cnt <= '0;
            cmd_wp    <= '0;
            cmd_rp    <= '0;
            cmd_cnt   <= '0;
            wdf_wp    <= '0;
            wdf_rp    <= '0;
            wdf_cnt   <= '0;
            rdy_q     <= 1'b0;
            wdf_rdy_q <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            if (!calib) begin
                if (calib_cnt == CAL_LAST)
                    calib <= 1'b1;
                else
                    calib_cnt <= calib_cnt + CW'(1);
            end
            if (cmd_push)
                cmd_wp <= cmd_wp + QW'(1);
            if (retire)
                cmd_rp <= cmd_rp + QW'(1);
            if (wdf_push)
                wdf_wp <= wdf_wp + QW'(1);
            if (wr_retire)
                wdf_rp <= wdf_rp + QW'(1);
            cmd_cnt   <= cmd_cnt_n;
            wdf_cnt   <= wdf_cnt_n;
            rdy_q     <= calib_n && (cmd_cnt_n != Q_FULL) && !refresh_stall_n && !inj_cmd;
            wdf_rdy_q <= calib_n && (wdf_cnt_n != Q_FULL) && !inj_wdf;
            if (err_set)
                err_q <= 1'b1;
        end
    end

    always_ff @(posedge uiclk) begin
        if (cmd_push)
            cmdq[cmd_wp] <= '{rd: app.app_cmd[0], addr: app.app_addr[MEM_ADDR_WIDTH+2:3]};
        if (wdf_push)
            wdfq[wdf_wp] <= '{data: app.app_wdf_data, mask: app.app_wdf_mask};
    end

    always_ff @(posedge uiclk) begin
        if (wr_retire) begin
            for (int b = 0; b < 16; b++) begin
                if (!wdf_head.mask[b])
                    mem[head.addr][8*b +: 8] <= wdf_head.data[8*b +: 8];
            end
        end
    end

    // READ_LATENCY-1 address stages, then the BRAM read into the output register.
    generate
        if (READ_LATENCY > 1) begin : g_rd_pipe
            logic [READ_LATENCY-2:0]   pv;
            logic [MEM_ADDR_WIDTH-1:0] pa [READ_LATENCY-1];

            always_ff @(posedge uiclk or posedge reset) begin
                if (reset) begin
                    pv <= '0;
                end else begin
                    pv[0] <= rd_retire;
                    for (int k = 1; k < READ_LATENCY - 1; k++)
                        pv[k] <= pv[k-1];
                end
            end

            always_ff @(posedge uiclk) begin
                pa[0] <= head.addr;
                for (int k = 1; k < READ_LATENCY - 1; k++)
                    pa[k] <= pa[k-1];
            end

            assign last_vld  = pv[READ_LATENCY-2];
            assign last_addr = pa[READ_LATENCY-2];
        end else begin : g_rd_direct
            assign last_vld  = rd_retire;
            assign last_addr = head.addr;
        end
    endgenerate

    always_ff @(posedge uiclk or posedge reset) begin
        if (reset) begin
            rd_vld_q  <= 1'b0;
            rd_data_q <= '0;
        end else begin
            rd_vld_q <= last_vld;
            if (last_vld)
                rd_data_q <= mem[last_addr];
        end
    end

    assign app.init_calib_complete = calib;
    assign app.app_rdy             = rdy_q;
    assign app.app_wdf_rdy         = wdf_rdy_q;
    assign app.app_rd_data         = rd_data_q;
    assign app.app_rd_data_valid   = rd_vld_q;
    assign app.app_rd_data_end     = rd_vld_q;
    assign app.err                 = err_q;

endmodule

// File: tb/tb_mig_app_responder.sv
// Scoreboard bench for mig_app_responder: directed vectors, expected read data queued at issue, monitor compares.
module tb_mig_app_responder;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    mig_app_responder_if ifc();

    mig_app_responder dut (
        .uiclk (clk),
        .reset (rst),
        .app   (ifc)
    );

    int n_checks = 0;
    int n_pass = 0;
    int n_unexpected = 0;
    int n_valid_seen = 0;
    int cyc = 0;
    logic [127:0] exp_q[$];
    logic [127:0] model [0:1023];

    // Cycles since reset release; matches the responder's refresh phase.
    always @(posedge clk) cyc <= rst ? 0 : cyc + 1;

    task automatic check(input string nm, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act === exp)
            n_pass++;
        else
            $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    endtask

    task automatic monitor();
        forever begin
            @(negedge clk);
            if (ifc.app_rd_data_valid) begin
                n_valid_seen++;
                check("rd_data_end", ifc.app_rd_data_end, 1);
                if (exp_q.size() == 0)
                    n_unexpected++;
                else
                    check("rd_data", ifc.app_rd_data, exp_q.pop_front());
            end
        end
    endtask

    function automatic void model_wr(input int w, input logic [127:0] d, input logic [15:0] m);
        for (int b = 0; b < 16; b++)
            if (!m[b]) model[w][8*b +: 8] = d[8*b +: 8];
    endfunction

    // All driving tasks start and end on a falling edge.
    task automatic wait_rdy(input bit need_wdf, output int waited);
        waited = 0;
        while (!(ifc.app_rdy && (!need_wdf || ifc.app_wdf_rdy)) && waited < 500) begin
            @(negedge clk);
            waited++;
        end
        if (waited >= 500)
            check("app_rdy_timeout", waited, 0);
    endtask

    task automatic send_cmd(input logic [2:0] cmd, input logic [27:0] addr, output int waited);
        wait_rdy(1'b0, waited);
        ifc.app_en   = 1'b1;
        ifc.app_cmd  = cmd;
        ifc.app_addr = addr;
        @(negedge clk);
        ifc.app_en = 1'b0;
    endtask

    task automatic send_read(input logic [27:0] addr, input logic [127:0] exp, output int waited);
        exp_q.push_back(exp);
        send_cmd(3'b001, addr, waited);
    endtask

    task automatic send_wdf(input logic [127:0] d, input logic [15:0] m);
        int n = 0;
        while (!ifc.app_wdf_rdy && n < 500) begin
            @(negedge clk);
            n++;
        end
        if (n >= 500)
            check("wdf_rdy_timeout", n, 0);
        ifc.app_wdf_wren = 1'b1;
        ifc.app_wdf_end  = 1'b1;
        ifc.app_wdf_data = d;
        ifc.app_wdf_mask = m;
        @(negedge clk);
        ifc.app_wdf_wren = 1'b0;
        ifc.app_wdf_end  = 1'b0;
    endtask

    task automatic send_write_both(input logic [27:0] addr, input logic [127:0] d, input logic [15:0] m);
        int w;
        wait_rdy(1'b1, w);
        ifc.app_en       = 1'b1;
        ifc.app_cmd      = 3'b000;
        ifc.app_addr     = addr;
        ifc.app_wdf_wren = 1'b1;
        ifc.app_wdf_end  = 1'b1;
        ifc.app_wdf_data = d;
        ifc.app_wdf_mask = m;
        @(negedge clk);
        ifc.app_en       = 1'b0;
        ifc.app_wdf_wren = 1'b0;
        ifc.app_wdf_end  = 1'b0;
    endtask

    initial begin
        int w, n, total_wait, nv0;
        int words [6] = '{1, 10, 11, 12, 13, 20};
        logic [127:0] d;

        ifc.app_en = 1'b0;
        ifc.app_cmd = 3'b000;
        ifc.app_addr = '0;
        ifc.app_wdf_data = '0;
        ifc.app_wdf_mask = '0;
        ifc.app_wdf_wren = 1'b0;
        ifc.app_wdf_end = 1'b0;
        fork
            monitor();
        join_none

        // Reset state and calibration countdown
        repeat (3) @(negedge clk);
        check("rst_calib", ifc.init_calib_complete, 0);
        check("rst_app_rdy", ifc.app_rdy, 0);
        check("rst_wdf_rdy", ifc.app_wdf_rdy, 0);
        check("rst_rd_valid", ifc.app_rd_data_valid, 0);
        check("rst_rd_data", ifc.app_rd_data, 0);
        check("rst_err", ifc.err, 0);
        rst = 1'b0;
        repeat (63) @(negedge clk);
        check("calib_at_63", ifc.init_calib_complete, 0);
        check("app_rdy_at_63", ifc.app_rdy, 0);
        @(negedge clk);
        check("calib_at_64", ifc.init_calib_complete, 1);
        check("app_rdy_at_64", ifc.app_rdy, 1);
        check("wdf_rdy_at_64", ifc.app_wdf_rdy, 1);

        // Write with data in the same cycle, then read back with latency measurement
        d = {32{4'h1}};
        send_write_both(28'h000008, d, 16'h0000);
        model_wr(1, d, 16'h0000);
        send_read(28'h000008, {32{4'h1}}, w);
        n = 0;
        while (!ifc.app_rd_data_valid && n < 64) begin
            @(negedge clk);
            n++;
        end
        check("rd_latency_after_retire", n, 8);

        // Commands ahead of data fill the command queue
        for (int i = 0; i < 4; i++)
            send_cmd(3'b000, 28'((10 + i) << 3), w);
        check("cmdq_full_app_rdy", ifc.app_rdy, 0);
        check("cmdq_full_wdf_rdy", ifc.app_wdf_rdy, 1);
        for (int i = 0; i < 4; i++) begin
            d = {4{32'hA5A5_0000 + 32'(i)}};
            send_wdf(d, 16'h0000);
            model_wr(10 + i, d, 16'h0000);
        end
        repeat (4) @(negedge clk);
        check("drained_app_rdy", ifc.app_rdy, 1);
        send_read(28'(10 << 3), {4{32'hA5A5_0000}}, w);
        send_read(28'(11 << 3), {4{32'hA5A5_0001}}, w);
        send_read(28'(12 << 3), {4{32'hA5A5_0002}}, w);
        send_read(28'(13 << 3), {4{32'hA5A5_0003}}, w);

        // Byte mask: data beat arrives before its command
        send_write_both(28'(20 << 3), '0, 16'h0000);
        model_wr(20, '0, 16'h0000);
        d = '1;
        send_wdf(d, 16'hFFFE);
        model_wr(20, d, 16'hFFFE);
        send_cmd(3'b000, 28'(20 << 3), w);
        send_read(28'(20 << 3), 128'h0000_0000_0000_0000_0000_0000_0000_00FF, w);

        // 32 back-to-back reads straddling the refresh stall at cycles 1008..1023
        while (cyc < 990) @(negedge clk);
        total_wait = 0;
        for (int i = 0; i < 32; i++) begin
            int wd;
            logic [27:0] a;
            wd = words[i % 6];
            a = 28'(wd << 3) | ((i % 2 == 1) ? 28'h0100000 : 28'h0);
            send_read(a, model[wd], w);
            total_wait += w;
        end
        check("refresh_app_rdy_low_cycles", total_wait, 16);
        n = 0;
        while (exp_q.size() != 0 && n < 200) begin
            @(negedge clk);
            n++;
        end
        check("refresh_reads_all_returned", exp_q.size(), 0);
        check("err_clean_before_illegal", ifc.err, 0);

        // Illegal command, then reset in the middle of a read burst
        nv0 = n_valid_seen;
        send_cmd(3'b010, 28'h000008, w);
        check("err_after_illegal", ifc.err, 1);
        repeat (15) @(negedge clk);
        check("illegal_no_valid", n_valid_seen - nv0, 0);
        for (int i = 0; i < 4; i++)
            send_read(28'((10 + i) << 3), model[10 + i], w);
        repeat (2) @(negedge clk);
        rst = 1'b1;
        exp_q.delete();
        nv0 = n_valid_seen;
        repeat (3) @(negedge clk);
        check("midrst_err_cleared", ifc.err, 0);
        check("midrst_valid", ifc.app_rd_data_valid, 0);
        check("midrst_app_rdy", ifc.app_rdy, 0);
        rst = 1'b0;
        repeat (40) @(negedge clk);
        check("no_valid_after_reset", n_valid_seen - nv0, 0);
        check("unexpected_valids", n_unexpected, 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
